pdm_record_ctrl: RTL

PDM_RECORD_CTRL -- requirements
Module: pdm_record_ctrl

---
 rtl/pdm_record_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pdm_record_ctrl.sv
// pdm_record_ctrl: records a 1-bit PDM microphone stream into word-wide
// sample memory and plays it back one bit per strobe.
// The recorder packs bits MSB-first into words and writes each full word.
// The player fetches words in order and shifts them out MSB-first.
module pdm_record_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pdm_strobe,
    input  logic                  pdm_bit,
    input  logic                  start_rec,
    input  logic                  start_play,
    input  logic                  stop,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  play_out,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   rec_len
);

    localparam int CNT_WIDTH = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0]  LAST_BIT = CNT_WIDTH'(WORD_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(WORD_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] WR_LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] WR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, RECORD, FETCH, PLAY} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH:0]     rd_ptr;
    logic [ADDR_WIDTH:0]     rd_ptr_inc;
    logic [CNT_WIDTH-1:0]    bit_cnt;
    logic [WORD_WIDTH-1:0]   rec_shift;
    logic [WORD_WIDTH-1:0]   rec_shift_next;
    logic [WORD_WIDTH-1:0]   play_shift;
    logic                    fetch_wait;
    logic                    last_write;

    assign rd_ptr_inc     = rd_ptr + LEN_ONE;
    assign rec_shift_next = {rec_shift[WORD_WIDTH-2:0], pdm_bit};
    assign last_write     = mem_we && (wr_ptr == WR_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; record beats play when both commands arrive together.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_rec)                          state_next = RECORD;
                else if (start_play && rec_len != '0)   state_next = FETCH;
            end
            RECORD: begin
                if (stop || last_write)                 state_next = IDLE;
            end
            FETCH: begin
                if (stop)                               state_next = IDLE;
                else if (fetch_wait)                    state_next = PLAY;
            end
            PLAY: begin
                if (stop)                               state_next = IDLE;
                else if (bit_cnt == FULL_CNT)
                    state_next = (rd_ptr_inc == rec_len) ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded straight from the state and pointers.
    always_comb begin
        busy     = (state != IDLE);
        mem_addr = (state == RECORD) ? wr_ptr : rd_ptr[ADDR_WIDTH-1:0];
    end

    // Recording path: shift in bits, issue one write per full word, count words.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rec_len   <= '0;
            rec_shift <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (state == IDLE && start_rec) begin
                wr_ptr    <= '0;
                rec_len   <= '0;
                rec_shift <= '0;
            end else if (state == RECORD) begin
                if (mem_we) begin
                    rec_len <= rec_len + LEN_ONE;
                    if (wr_ptr != WR_LAST) wr_ptr <= wr_ptr + WR_ONE;
                end
                if (!stop && pdm_strobe) begin
                    rec_shift <= rec_shift_next;
                    if (bit_cnt == LAST_BIT) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= rec_shift_next;
                    end
                end
            end
        end
    end

    // Bit counter shared by recording (bits per word) and playback (bits played).
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_rec) bit_cnt <= '0;
                end
                RECORD: begin
                    if (stop)
                        bit_cnt <= '0;
                    else if (pdm_strobe)
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_ONE;
                end
                FETCH: begin
                    if (fetch_wait) bit_cnt <= '0;
                end
                PLAY: begin
                    if (pdm_strobe && bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + CNT_ONE;
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    // Playback path: two-cycle fetch (address, then data), then shift out per strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= '0;
            play_shift <= '0;
            fetch_wait <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!start_rec && start_play) begin
                        rd_ptr     <= '0;
                        fetch_wait <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!stop) begin
                        if (fetch_wait) begin
                            play_shift <= mem_rdata;
                            fetch_wait <= 1'b0;
                        end else begin
                            fetch_wait <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (!stop) begin
                        if (bit_cnt == FULL_CNT) begin
                            rd_ptr     <= rd_ptr_inc;
                            fetch_wait <= 1'b0;
                        end else if (pdm_strobe) begin
                            play_shift <= {play_shift[WORD_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Playback bit: MSB captured on each strobe, forced low whenever PLAY is left.
    always_ff @(posedge clock) begin
        if (reset)
            play_out <= 1'b0;
        else if (state_next != PLAY)
            play_out <= 1'b0;
        else if (state == PLAY && pdm_strobe && bit_cnt != FULL_CNT)
            play_out <= play_shift[WORD_WIDTH-1];
    end

    // Done pulses on every return to IDLE, and on a play request with nothing recorded.
    always_ff @(posedge clock) begin
        if (reset)
            done <= 1'b0;
        else
            done <= (state != IDLE && state_next == IDLE) ||
                    (state == IDLE && start_play && !start_rec && rec_len == '0);
    end

endmodule
